keypad_scan: RTL
================

// Module: keypad_scan
// PURPOSE
// - Input-side counterpart of the 8x8 LED matrix scanner: scans a 4x4 key matrix and reports one debounced key.
// - Drives one column low at a time and samples the 4 row lines at the end of each column slot.
// - Debounces across whole scan frames and reports a 4-bit key code with press and release pulses.
// - Sits beside the display driver and feeds user input (character select, scroll control) to the top level.
// PARAMETERS
// - SCAN_DIV        12  prescaler width; scan_tick fires once every 2**SCAN_DIV clk_in cycles (legal >= 2).
// - DEBOUNCE_SCANS  4   consecutive agreeing frames needed to accept a press or a release (legal 2..15).
// PORTS
// - clk_in        in   1  system clock.
// - reset         in   1  asynchronous, active-high reset.
// - key_row_in    in   4  row lines, active-low, externally pulled up, asynchronous to clk_in.
// - key_col_out   out  4  column drive, active-low one-hot (the driven column is 0).
// - key_code      out  4  code of the accepted key = col*4 + row; held until the next accepted press.
// - key_valid     out  1  level; high while a debounced key is held.
// - key_pressed   out  1  one-cycle pulse when a press is accepted.
// - key_released  out  1  one-cycle pulse when a release is accepted.
// - multi_key     out  1  level; high if the last completed frame saw more than one key down.
// BEHAVIOUR
// - Reset values (all applied immediately): prescaler 0, column index 0, key_col_out=4'b1110, key_code=0,
//   all flags 0, FSM=IDLE, frame accumulators cleared. No release pulse is produced by reset.
// - Synchronisation: key_row_in passes through a 2-flop synchroniser before it is used.
// - Prescaler: a SCAN_DIV-bit counter that wraps. scan_tick is high for one cycle when the counter is all-ones.
// - Scan, on each scan_tick:
//   - Sample the synchronised rows for the current column; row r is pressed when its line is 0.
//   - Then advance the column index 0->1->2->3->0 and update key_col_out on the same edge.
// - Frame accumulation:
//   - Record the lowest pressed code in the frame (scan order col 0..3, row 0..3) and count pressed keys (saturate at 2).
//   - Frame completes on the tick that samples column 3.
//   - The registered frame result (hit, code, multi) and a frame_done strobe are valid in the following cycle.
//   - The accumulators then clear.
// - multi_key updates on every frame_done.
// - FSM (advances only on frame_done; cnt is a 4-bit agreement counter):
//   - IDLE:     hit -> cand=code, cnt=1, go to PRESS_CHK.
//   - PRESS_CHK:
//     - hit with code==cand -> cnt+1; when cnt reaches DEBOUNCE_SCANS: key_code=cand, key_valid=1,
//       pulse key_pressed, go to HELD.
//     - hit with a different code -> cand=new code, cnt=1, stay.
//     - no hit -> go to IDLE.
//   - HELD:     hit with code==key_code -> stay; otherwise cnt=1, go to RELEASE_CHK.
//   - RELEASE_CHK:
//     - hit with code==key_code -> go to HELD.
//     - otherwise cnt+1; when cnt reaches DEBOUNCE_SCANS: key_valid=0, pulse key_released, go to IDLE.
//     - A different key can be accepted only after this release completes.
// - Latency: key_pressed is asserted in the cycle after frame_done of the DEBOUNCE_SCANS-th agreeing frame.
//   From a clean press, that is DEBOUNCE_SCANS to DEBOUNCE_SCANS+1 frames (frame = 4*2**SCAN_DIV cycles).
// - Pulses are never asserted together. Each pulse lasts exactly one clk_in cycle.
// TESTING (SCAN_DIV=2, DEBOUNCE_SCANS=3; frame = 16 cycles)
// - The keypad model pulls row r low while key (c,r) is held and key_col_out[c]=0.
// - 1. Reset, no keys -> key_col_out cycles 1110,1101,1011,0111 with 4 cycles each; all flags stay 0.
// - 2. Hold key col2,row1 -> exactly one key_pressed pulse within 48..64 cycles; key_code=9; key_valid=1.
// - 3. Hold key 6 for one frame, then release -> no key_pressed; key_valid stays 0; FSM returns to IDLE.
// - 4. From HELD on key 9, release -> one key_released pulse within 48..64 cycles; key_valid=0; key_code stays 9.
// - 5. Hold keys 5 and 10 together -> key_code=5, multi_key=1; release both -> multi_key=0 after the next frame.
// - 6. Assert reset mid-HELD -> key_valid=0 and key_col_out=1110 immediately; no key_released pulse.
//   Releasing reset with the key still held -> a fresh key_pressed pulse.

Source files
------------

// File: rtl/keypad_scan_if.sv
// keypad_scan_if
// Bundles the keypad matrix lines and the debounced key report.
//   key_row_in   : row lines, active-low, pulled up (keypad -> scanner)
//   key_col_out  : column drive, active-low one-hot (scanner -> keypad)
//   key_code     : accepted key code, col*4 + row
//   key_valid    : high while a debounced key is held
//   key_pressed  : one-cycle press pulse
//   key_released : one-cycle release pulse
//   multi_key    : last completed frame saw more than one key down
// master = the scanner, slave = keypad model / consumer.
interface keypad_scan_if;
  logic [3:0] key_row_in;
  logic [3:0] key_col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;
  logic       key_released;
  logic       multi_key;

  modport master (
    input  key_row_in,
    output key_col_out, key_code, key_valid, key_pressed, key_released, multi_key
  );

  modport slave (
    output key_row_in,
    input  key_col_out, key_code, key_valid, key_pressed, key_released, multi_key
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan
// Scans a 4x4 key matrix one column at a time, debounces across whole scan
// frames and reports one key with press/release pulses.
// Ports:
//   clk_in : system clock
//   reset  : asynchronous, active-high reset
//   kp     : keypad_scan_if.master (matrix lines + key report)
module keypad_scan #(
  parameter int SCAN_DIV       = 12,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk_in,
  input  logic          reset,
  keypad_scan_if.master kp
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  // row synchroniser
  logic [3:0] row_s1_q, row_s2_q;

  // prescaler and column index
  logic [SCAN_DIV-1:0] presc_q, presc_d;
  logic [1:0]          col_q, col_d;
  logic                scan_tick;

  // frame accumulators
  logic       acc_hit_q, acc_hit_d;
  logic [3:0] acc_code_q, acc_code_d;
  logic [1:0] acc_cnt_q, acc_cnt_d;

  // registered frame result
  logic       frm_hit_q, frm_hit_d;
  logic [3:0] frm_code_q, frm_code_d;
  logic       frm_multi_q, frm_multi_d;
  logic       frame_done_q, frame_done_d;

  // debounce FSM and outputs
  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       pressed_q, pressed_d;
  logic       released_q, released_d;
  logic       multi_q, multi_d;

  // per-column sample decode
  logic [3:0] col_pressed;
  logic       col_hit;
  logic [1:0] col_row;
  logic [2:0] col_cnt;
  logic [2:0] cnt_sum;
  logic       nxt_hit;
  logic [3:0] nxt_code;
  logic [1:0] nxt_cnt;
  logic [3:0] cnt_inc;

  assign scan_tick = &presc_q;

  always_comb begin
    col_pressed = ~row_s2_q;
    col_hit     = |col_pressed;
    col_row     = 2'd0;
    // descending walk leaves the lowest pressed row
    for (int r = 3; r >= 0; r--) begin
      if (col_pressed[r]) col_row = r[1:0];
    end
    col_cnt  = {2'b0, col_pressed[0]} + {2'b0, col_pressed[1]}
             + {2'b0, col_pressed[2]} + {2'b0, col_pressed[3]};
    cnt_sum  = {1'b0, acc_cnt_q} + col_cnt;
    nxt_cnt  = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
    nxt_hit  = acc_hit_q | col_hit;
    // earlier columns always win, so only the first hit in a frame sets the code
    nxt_code = acc_hit_q ? acc_code_q : {col_q, col_row};
  end

  // scan / frame accumulation
  always_comb begin
    presc_d      = presc_q + 1'b1;
    col_d        = col_q;
    acc_hit_d    = acc_hit_q;
    acc_code_d   = acc_code_q;
    acc_cnt_d    = acc_cnt_q;
    frm_hit_d    = frm_hit_q;
    frm_code_d   = frm_code_q;
    frm_multi_d  = frm_multi_q;
    frame_done_d = 1'b0;
    if (scan_tick) begin
      col_d = col_q + 2'd1;
      if (col_q == 2'd3) begin
        frm_hit_d    = nxt_hit;
        frm_code_d   = nxt_code;
        frm_multi_d  = (nxt_cnt == 2'd2);
        frame_done_d = 1'b1;
        acc_hit_d    = 1'b0;
        acc_code_d   = 4'd0;
        acc_cnt_d    = 2'd0;
      end else begin
        acc_hit_d  = nxt_hit;
        acc_code_d = nxt_code;
        acc_cnt_d  = nxt_cnt;
      end
    end
  end

  // debounce FSM, steps once per completed frame
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    pressed_d   = 1'b0;
    released_d  = 1'b0;
    multi_d     = multi_q;
    cnt_inc     = cnt_q + 4'd1;
    if (frame_done_q) begin
      multi_d = frm_multi_q;
      case (state_q)
        IDLE: begin
          if (frm_hit_q) begin
            cand_d  = frm_code_q;
            cnt_d   = 4'd1;
            state_d = PRESS_CHK;
          end
        end
        PRESS_CHK: begin
          if (!frm_hit_q) begin
            state_d = IDLE;
          end else if (frm_code_q == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_N) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              pressed_d   = 1'b1;
              state_d     = HELD;
            end
          end else begin
            cand_d = frm_code_q;
            cnt_d  = 4'd1;
          end
        end
        HELD: begin
          if (!(frm_hit_q && frm_code_q == key_code_q)) begin
            cnt_d   = 4'd1;
            state_d = RELEASE_CHK;
          end
        end
        RELEASE_CHK: begin
          if (frm_hit_q && frm_code_q == key_code_q) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_N) begin
              key_valid_d = 1'b0;
              released_d  = 1'b1;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      row_s1_q     <= 4'hF;
      row_s2_q     <= 4'hF;
      presc_q      <= '0;
      col_q        <= 2'd0;
      acc_hit_q    <= 1'b0;
      acc_code_q   <= 4'd0;
      acc_cnt_q    <= 2'd0;
      frm_hit_q    <= 1'b0;
      frm_code_q   <= 4'd0;
      frm_multi_q  <= 1'b0;
      frame_done_q <= 1'b0;
      state_q      <= IDLE;
      cand_q       <= 4'd0;
      cnt_q        <= 4'd0;
      key_code_q   <= 4'd0;
      key_valid_q  <= 1'b0;
      pressed_q    <= 1'b0;
      released_q   <= 1'b0;
      multi_q      <= 1'b0;
    end else begin
      row_s1_q     <= kp.key_row_in;
      row_s2_q     <= row_s1_q;
      presc_q      <= presc_d;
      col_q        <= col_d;
      acc_hit_q    <= acc_hit_d;
      acc_code_q   <= acc_code_d;
      acc_cnt_q    <= acc_cnt_d;
      frm_hit_q    <= frm_hit_d;
      frm_code_q   <= frm_code_d;
      frm_multi_q  <= frm_multi_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      pressed_q    <= pressed_d;
      released_q   <= released_d;
      multi_q      <= multi_d;
    end
  end

  // column drive follows col_q directly, so reset gives 1110 at once
  assign kp.key_col_out  = ~(4'b0001 << col_q);
  assign kp.key_code     = key_code_q;
  assign kp.key_valid    = key_valid_q;
  assign kp.key_pressed  = pressed_q;
  assign kp.key_released = released_q;
  assign kp.multi_key    = multi_q;

endmodule
